// File: rtl/seg_pkg.sv
// seg_pkg: shared display7 codes and shadow state type
// for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] CODE_0 = 6'h00;
  localparam logic [CODE_W-1:0] CODE_1 = 6'h01;
  localparam logic [CODE_W-1:0] CODE_2 = 6'h02;
  localparam logic [CODE_W-1:0] CODE_3 = 6'h03;
  localparam logic [CODE_W-1:0] CODE_4 = 6'h04;
  localparam logic [CODE_W-1:0] CODE_5 = 6'h05;
  localparam logic [CODE_W-1:0] CODE_6 = 6'h06;
  localparam logic [CODE_W-1:0] CODE_7 = 6'h07;
  localparam logic [CODE_W-1:0] CODE_8 = 6'h08;
  localparam logic [CODE_W-1:0] CODE_9 = 6'h09;

  localparam logic [CODE_W-1:0] CODE_C = 6'h0A;
  localparam logic [CODE_W-1:0] CODE_D = 6'h0B;
  localparam logic [CODE_W-1:0] CODE_E = 6'h0C;
  localparam logic [CODE_W-1:0] CODE_L = 6'h0D;
  localparam logic [CODE_W-1:0] CODE_N = 6'h0E;
  localparam logic [CODE_W-1:0] CODE_O = 6'h0F;
  localparam logic [CODE_W-1:0] CODE_P = 6'h10;
  localparam logic [CODE_W-1:0] CODE_S = 6'h11;

  localparam logic [CODE_W-1:0] CODE_DASH = 6'h3F;

  typedef enum logic {
    SH_EMPTY,
    SH_FULL
  } sh_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: per-digit dwell counter and digit index.
// Ports: clk, rst_n; digit_idx = digit being scanned;
//   frame_tick = high on the cycle whose edge wraps
//   digit_idx back to 0 (frame boundary).
module seg_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] digit_idx,
  output logic          frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic          term;
  logic          last_digit;

  assign term       = (cnt == CNT_LAST);
  assign last_digit = (digit_idx == IDX_LAST);
  assign frame_tick = term && last_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (term) begin
      cnt <= '0;
      if (last_digit)
        digit_idx <= '0;
      else
        digit_idx <= digit_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes one display7 decoder over
// NUM_DIGITS common-anode digits with frame-atomic updates.
// Ports: clk, rst_n (async, active low);
//   msg_valid/msg_ready/msg_data: whole-message handshake,
//     digit 0 in msg_data[5:0];
//   blink_en: blink the whole display;
//   seg_code: code for the selected digit's decoder;
//   digit_en: active-low one-hot anode selects.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         msg_valid,
  output logic                         msg_ready,
  input  logic [CODE_W*NUM_DIGITS-1:0] msg_data,
  input  logic                         blink_en,
  output logic [CODE_W-1:0]            seg_code,
  output logic [NUM_DIGITS-1:0]        digit_en
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST =
    FW'(BLINK_FRAMES - 1);

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] buf_t;

  logic [IW-1:0] digit_idx;
  logic          frame_tick;

  sh_state_t     sh_state;
  buf_t          shadow;
  buf_t          active;

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          dark;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // Shadow handshake. The commit only happens from FULL,
  // so a message accepted on a boundary waits one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_state  <= SH_EMPTY;
      msg_ready <= 1'b1;
      shadow    <= '0;
      active    <= {NUM_DIGITS{CODE_DASH}};
    end else begin
      unique case (sh_state)
        SH_EMPTY: begin
          if (msg_valid) begin
            shadow    <= buf_t'(msg_data);
            sh_state  <= SH_FULL;
            msg_ready <= 1'b0;
          end
        end
        SH_FULL: begin
          if (frame_tick) begin
            active    <= shadow;
            sh_state  <= SH_EMPTY;
            msg_ready <= 1'b1;
          end
        end
        default: begin
          sh_state  <= SH_EMPTY;
          msg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Blink phase advances once per BLINK_FRAMES frames
  // and is parked at 0 while blinking is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign dark = blink_en && blink_phase;

  // Output stage lags digit_idx by one cycle, so the first
  // digit of a frame already sees a freshly committed buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_code <= CODE_DASH;
      digit_en <= ~NUM_DIGITS'(1);
    end else begin
      seg_code <= active[digit_idx];
      if (dark)
        digit_en <= '1;
      else
        digit_en <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule
